// File: rtl/booth_seq_approx.sv
// Sequential radix-4 Booth multiplier, one digit per cycle.
// Optional approximate mode drops the lowest Booth digits.
module booth_seq_approx #(
    parameter int WIDTH         = 32,
    parameter int APPROX_DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 signed_mode,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int D  = WIDTH / 2 + 1;
    localparam int PW = 2 * WIDTH;
    localparam int YW = WIDTH + 3;
    localparam int CW = $clog2(D + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [YW-1:0]   ybits;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   skip;
    logic [PW-1:0]   term;
    logic [PW-1:0]   acc_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Recode the current Booth digit from the low three multiplier bits
    // and form the partial product; dropped digits contribute nothing.
    always_comb begin
        term = '0;
        unique case (ybits[2:0])
            3'b001, 3'b010: term = mcand;
            3'b011:         term = mcand << 1;
            3'b100:         term = -(mcand << 1);
            3'b101, 3'b110: term = -mcand;
            default:        term = '0;
        endcase
        if (skip != '0) begin
            term = '0;
        end
        acc_next = acc + term;
    end

    // Control FSM plus datapath: capture, D accumulate steps, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            p     <= '0;
            mcand <= '0;
            ybits <= '0;
            cnt   <= '0;
            skip  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= {{WIDTH{signed_mode & x[WIDTH-1]}}, x};
                        ybits <= {{2{signed_mode & y[WIDTH-1]}}, y, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                        skip  <= approx_en ? CW'(APPROX_DIGITS) : '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    mcand <= mcand << 2;
                    ybits <= ybits >> 2;
                    cnt   <= cnt + CW'(1);
                    if (skip != '0) begin
                        skip <= skip - CW'(1);
                    end
                    if (cnt == CW'(D - 1)) begin
                        p     <= acc_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_approx.sv
// Scoreboard bench for booth_seq_approx (WIDTH=8, APPROX_DIGITS=2).
// Stimulus pushes expected products; a negedge monitor pops and compares.
module tb_booth_seq_approx;

    localparam int W = 8;
    localparam int A = 2;
    localparam int LAT = W / 2 + 1;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    x;
    logic [W-1:0]    y;
    logic            signed_mode;
    logic            approx_en;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  p;

    typedef struct {
        logic [15:0] e;
        int          a;
    } exp_t;

    exp_t q[$];
    int   tests;
    int   fails;
    int   cyc;
    logic prev_valid;
    logic [15:0] hold;

    booth_seq_approx #(
        .WIDTH(W),
        .APPROX_DIGITS(A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x(x),
        .y(y),
        .signed_mode(signed_mode),
        .approx_en(approx_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p(p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] ref_p(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic s,
                                          input logic ap);
        longint xa;
        longint yb;
        longint pr;
        logic [3:0] lo;
        xa = s ? longint'($signed(a)) : longint'(a);
        yb = s ? longint'($signed(b)) : longint'(b);
        lo = b[3:0];
        if (ap) yb = yb - longint'($signed(lo));
        pr = xa * yb;
        return pr[15:0];
    endfunction

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    // Monitor: latency on each rising out_valid, value on each handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'(p), 32'hDEAD_BEEF);
                end else begin
                    chk("latency", 32'(cyc), 32'(q[0].a + LAT));
                end
            end
            if (out_valid && out_ready && q.size() != 0) begin
                chk("product", 32'(p), 32'(q[0].e));
                void'(q.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    task automatic rnd_ready(input logic rnd);
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic ap,
                        input logic [15:0] e, input logic rnd);
        exp_t t;
        logic ok;
        int n;
        x = a;
        y = b;
        signed_mode = s;
        approx_en = ap;
        in_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) begin
                t.e = e;
                t.a = cyc + 1;
                q.push_back(t);
            end
            @(posedge clk);
            #1;
            if (!ok) rnd_ready(rnd);
            n++;
        end
        if (!ok) chk("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        x = W'($urandom);
        y = W'($urandom);
        rnd_ready(rnd);
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        prev_valid = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        x = '0;
        y = '0;
        signed_mode = 1'b0;
        approx_en = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_p", 32'(p), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        send(8'hFD, 8'h05, 1'b1, 1'b0, 16'hFFF1, 1'b0);
        send(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 1'b0);
        send(8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 1'b0);
        send(8'h0A, 8'h17, 1'b1, 1'b1, 16'h00A0, 1'b0);
        send(8'h0A, 8'h17, 1'b1, 1'b0, 16'h00E6, 1'b0);
        drain();

        out_ready = 1'b0;
        send(8'h07, 8'hF9, 1'b1, 1'b0, 16'hFFCF, 1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        hold = p;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            x = W'($urandom);
            y = W'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_p_stable", 32'(p), 32'hFFCF);
            chk("bp_p_hold", 32'(p), 32'(hold));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (8) @(negedge clk);
        chk("bp_no_capture", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        send(8'h33, 8'h44, 1'b0, 1'b0, 16'h0D8C, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_p", 32'(p), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("abort_no_stale", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 80; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic s;
            logic ap;
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            ap = 1'($urandom);
            send(a, b, s, ap, ref_p(a, b, s, ap), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                rnd_ready(1'b1);
            end
        end
        drain();
        repeat (8) @(negedge clk);
        chk("stream_queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_seq_approx.md
BOOTH_SEQ_APPROX -- requirements
Module: booth_seq_approx

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width; even, >= 4.
REQ-002 SHALL provide parameter APPROX_DIGITS, default 4, number of low-order Booth digits dropped in approximate mode; range 0..WIDTH/2.
REQ-003 SHALL provide port clk  input  1  rising-edge clock; sole clock.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  operand request.
REQ-006 SHALL provide port in_ready  output  1  block can accept operands.
REQ-007 SHALL provide port x  input  WIDTH  multiplicand.
REQ-008 SHALL provide port y  input  WIDTH  multiplier (Booth-recoded operand).
REQ-009 SHALL provide port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL provide port approx_en  input  1  1 = drop low APPROX_DIGITS Booth digits.
REQ-011 SHALL provide port out_valid  output  1  result available.
REQ-012 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-013 SHALL provide port p  output  2*WIDTH  product.

Function
REQ-014 SHALL have states IDLE, BUSY, DONE, with in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-015 SHALL accept in IDLE when in_valid=1 at a clk edge, capturing x, y, signed_mode and approx_en; later input changes SHALL NOT affect the operation.
REQ-016 SHALL extend operands to WIDTH+2 bits: sign-extend when signed_mode=1, zero-extend when 0.
REQ-017 SHALL radix-4 recode the extended y into D = WIDTH/2+1 digits d_k in {-2,-1,0,+1,+2}, digit k from bits {y[2k+1], y[2k], y[2k-1]}, with y[-1] = 0.
REQ-018 SHALL process exactly one digit per BUSY cycle, LSB digit first, adding d_k*x*4^k into a 2*WIDTH-bit accumulator; all arithmetic is modulo 2^(2*WIDTH).
REQ-019 SHALL, when captured approx_en=1, treat digits 0..APPROX_DIGITS-1 as zero, yielding p = x*(y - signed(y[2A-1:0])) mod 2^(2*WIDTH) with A = APPROX_DIGITS; with A=0 this equals the exact result.
REQ-020 SHALL otherwise produce p = exact x*y (signed or unsigned per captured mode) mod 2^(2*WIDTH).
REQ-021 SHALL stay in BUSY for exactly D cycles regardless of approx_en or operand values; out_valid SHALL rise D clk edges after the accepting edge.
REQ-022 SHALL hold p and out_valid stable in DONE until out_ready=1 at a clk edge, then go to IDLE; in_ready SHALL be 0 in DONE.
REQ-023 SHALL ignore in_valid in BUSY and DONE with no capture or side effect.
REQ-024 SHALL hold p at its last value in IDLE and BUSY; p is meaningful only while out_valid=1.

Reset
REQ-025 SHALL on rst=1 at a clk edge enter IDLE, clear the accumulator and p to 0, and set out_valid=0 and in_ready=1 from the next cycle.
REQ-026 SHALL give rst priority over all other inputs, aborting any BUSY or DONE operation without producing a result.

Verification (WIDTH=8, APPROX_DIGITS=2, D=5)
REQ-027 SHALL check signed x=8'hFD (-3), y=8'h05 -> p=16'hFFF1, out_valid exactly 5 edges after acceptance.
REQ-028 SHALL check unsigned x=8'hFF, y=8'hFF -> p=16'hFE01; signed x=8'h80, y=8'h80 -> p=16'h4000.
REQ-029 SHALL check approx_en=1, signed, x=8'h0A, y=8'h17 -> p=16'h00A0; the same operands with approx_en=0 -> p=16'h00E6.
REQ-030 SHALL check a backpressure case, out_ready=0 for 3 cycles while in_valid pulses -> p and out_valid stable, in_ready=0, no new capture.
REQ-031 SHALL check rst=1 at the 3rd BUSY cycle -> next cycle out_valid=0, p=0, in_ready=1, and no stale result afterwards.
REQ-032 SHALL run a random back-to-back stream (both modes, approx on/off) against the REQ-019/REQ-020 formulas, with no lost or duplicated results.
